x2_pipe: RTL

X2_PIPE -- requirements
Module: x2_pipe

---
 rtl/x2_pkg.sv | 13 +
 rtl/x2_core.sv | 26 ++
 rtl/x2_pipe.sv | 91 +++++++++
 3 files changed

// File: rtl/x2_pkg.sv
// rtl/x2_pkg.sv - shared widths and output bit positions for the x2 lane pipeline
package x2_pkg;
  localparam int X2_IN_W  = 10;
  localparam int X2_OUT_W = 7;

  localparam int K_B = 0;
  localparam int L_B = 1;
  localparam int M_B = 2;
  localparam int N_B = 3;
  localparam int O_B = 4;
  localparam int P_B = 5;
  localparam int Q_B = 6;
endpackage

// File: rtl/x2_core.sv
// rtl/x2_core.sv - combinational 10-in / 7-out lane decode
module x2_core
  import x2_pkg::*;
(
  input  logic [X2_IN_W-1:0]  in_bits,
  output logic [X2_OUT_W-1:0] out_bits
);

  logic a, b, c, d, e, f, g, h, i, j;

  assign {j, i, h, g, f, e, d, c, b, a} = in_bits;

  always_comb begin
    out_bits = '0;
    out_bits[K_B] = ~(h & i & ~j);
    out_bits[L_B] = i | (h ^ j);
    out_bits[M_B] = ~h & ~i & ~j;
    out_bits[N_B] = ~(~a & ~b & ~c & ~h & i & ~j);
    out_bits[O_B] = ~g | ~h | (i & j);
    out_bits[P_B] = ~g | (~i & ~j) | (f & ~h & i & j) | (d & ~e & h & ~j)
                  | (~a & ~b & c & h & i & j) | (~a & ~b & c & ~h & ~i);
    out_bits[Q_B] = ~g | (~h & ~i & ~j) | (f & ~h & i & j) | (h & ~i & j)
                  | (d & e & h & i & ~j) | (~a & ~b & ~c & h & j);
  end

endmodule

// File: rtl/x2_pipe.sv
// rtl/x2_pipe.sv - LANES-wide x2 decode behind a DEPTH-stage stallable pipeline with q hit counter
module x2_pipe
  import x2_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [X2_IN_W*LANES-1:0]  in_vec,
  input  logic [X2_OUT_W-1:0]       inv_mask,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [X2_OUT_W*LANES-1:0] out_vec,
  input  logic                      stat_clr,
  output logic [CNT_W-1:0]          q_hits
);

  localparam int VW = X2_OUT_W * LANES;

  logic [VW-1:0]            core_vec;
  logic [VW-1:0]            stage_in;
  logic [DEPTH-1:0][VW-1:0] data_q, data_d;
  logic [DEPTH-1:0]         vld_q, vld_d;
  logic [CNT_W-1:0]         hits_q, hits_d;
  logic                     adv;
  logic                     any_q;
  logic                     hit;

  for (genvar ln = 0; ln < LANES; ln++) begin : g_lane
    x2_core u_core (
      .in_bits  (in_vec[X2_IN_W*ln +: X2_IN_W]),
      .out_bits (core_vec[X2_OUT_W*ln +: X2_OUT_W])
    );
  end

  // Mask is folded in before stage 1 so it is captured with the data on accept.
  assign stage_in  = core_vec ^ {LANES{inv_mask}};
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[DEPTH-1];
  assign out_vec   = data_q[DEPTH-1];
  assign q_hits    = hits_q;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (adv) begin
      data_d[0] = stage_in;
      vld_d[0]  = in_valid;
      for (int s = 1; s < DEPTH; s++) begin
        data_d[s] = data_q[s-1];
        vld_d[s]  = vld_q[s-1];
      end
    end
  end

  always_comb begin
    any_q = 1'b0;
    for (int ln = 0; ln < LANES; ln++) begin
      any_q = any_q | out_vec[X2_OUT_W*ln + Q_B];
    end
  end

  assign hit = out_valid & out_ready & any_q;

  always_comb begin
    hits_d = hits_q;
    if (stat_clr) begin
      hits_d = '0;
    end else if (hit && (hits_q != {CNT_W{1'b1}})) begin
      hits_d = hits_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= '0;
      hits_q <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      hits_q <= hits_d;
    end
  end

endmodule
